// File: rtl/sub1_pkg.sv
// rtl/sub1_pkg.sv - shared types and constants for the sub1 output packer
package sub1_pkg;

  // Number of payload bytes carried by one frame: g0, g1, g2, h0, h1, h2.
  localparam int FRAME_BYTES = 6;

  // Byte index of the final byte of a frame, the one that carries out_last.
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  // One captured frame. bytes[0] is sent first (g0) and bytes[5] last (h2).
  typedef struct packed {
    logic [1:0]                  tag;
    logic [FRAME_BYTES-1:0][7:0] bytes;
  } frame_t;

  // Serializer states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sub1_out_packer_if.sv
// rtl/sub1_out_packer_if.sv - sub1 capture inputs, output byte stream and status
interface sub1_out_packer_if #(
  parameter int CNT_W = 8
);

  // Frame capture side, driven by sub1.
  logic             sig_e;
  logic             sig_f_0;
  logic             sig_f_1;
  logic [7:0]       sig_g_0;
  logic [7:0]       sig_g_1;
  logic [7:0]       sig_g_2;
  logic [7:0]       sig_h_0;
  logic [7:0]       sig_h_1;
  logic [7:0]       sig_h_2;

  // Byte stream towards the next stage.
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [1:0]       out_tag;
  logic             out_last;

  // Status.
  logic             full;
  logic [CNT_W-1:0] drop_cnt;

  // The packer itself: consumes frames, produces the stream and status.
  modport master (
    input  sig_e, sig_f_0, sig_f_1,
    input  sig_g_0, sig_g_1, sig_g_2,
    input  sig_h_0, sig_h_1, sig_h_2,
    input  out_ready,
    output out_valid, out_data, out_tag, out_last,
    output full, drop_cnt
  );

  // The surroundings: frame producer plus stream consumer.
  modport slave (
    output sig_e, sig_f_0, sig_f_1,
    output sig_g_0, sig_g_1, sig_g_2,
    output sig_h_0, sig_h_1, sig_h_2,
    output out_ready,
    input  out_valid, out_data, out_tag, out_last,
    input  full, drop_cnt
  );

endinterface

// File: rtl/sub1_frame_fifo.sv
// rtl/sub1_frame_fifo.sv - small frame FIFO with head and next-entry lookahead
module sub1_frame_fifo
  import sub1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  frame_t i_data,
  input  logic   i_pop,
  output frame_t o_head,
  output frame_t o_next,
  output logic   o_full,
  output logic   o_empty,
  output logic   o_multi
);

  localparam int AW = $clog2(DEPTH);

  frame_t        r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_full;
  logic [AW:0]   w_wptr_nxt;
  logic [AW:0]   w_rptr_nxt;
  logic [AW:0]   w_rptr_inc;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = r_full;
  assign w_do_pop   = i_pop && !o_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still legal then.
  assign w_do_push  = i_push && (!r_full || w_do_pop);
  assign w_rptr_inc = r_rptr + (AW+1)'(1);

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_next  = r_mem[w_rptr_inc[AW-1:0]];
  // At least two entries held: the serializer can chain straight into o_next.
  assign o_multi = !o_empty && (w_rptr_inc != r_wptr);

  // Pointer advance for this edge.
  always_comb begin
    w_wptr_nxt = r_wptr + (AW+1)'(w_do_push);
    w_rptr_nxt = r_rptr + (AW+1)'(w_do_pop);
  end

  // Frame storage; contents only matter between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  // Pointers and the registered full flag (MSBs differ, index bits equal).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_full <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
    end
  end

endmodule

// File: rtl/sub1_out_packer.sv
// rtl/sub1_out_packer.sv - captures sub1 frames and serializes them onto a byte stream
module sub1_out_packer
  import sub1_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  sub1_out_packer_if.master bus
);

  frame_t           w_in_frame;
  frame_t           w_head;
  frame_t           w_next;
  logic             w_full;
  logic             w_empty;
  logic             w_multi;
  logic             w_hs;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  state_t           r_state;
  state_t           w_state_nxt;
  frame_t           r_frame;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_drop_cnt;

  // Assemble the frame presented by sub1 this cycle.
  always_comb begin
    w_in_frame          = '0;
    w_in_frame.tag      = {bus.sig_f_1, bus.sig_f_0};
    w_in_frame.bytes[0] = bus.sig_g_0;
    w_in_frame.bytes[1] = bus.sig_g_1;
    w_in_frame.bytes[2] = bus.sig_g_2;
    w_in_frame.bytes[3] = bus.sig_h_0;
    w_in_frame.bytes[4] = bus.sig_h_1;
    w_in_frame.bytes[5] = bus.sig_h_2;
  end

  assign w_hs   = (r_state == SEND) && bus.out_ready;
  assign w_pop  = w_hs && (r_idx == LAST_IDX);
  assign w_push = bus.sig_e && (!w_full || w_pop);
  assign w_drop = bus.sig_e && w_full && !w_pop;

  sub1_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in_frame),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_multi (w_multi)
  );

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Serializer next state: chain frames without a gap whenever another is available.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_pop && !w_multi && !w_push) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Current frame and byte index. On the final byte the next frame comes from the
  // FIFO's second entry, or straight from the capture port if it is arriving now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_frame <= w_head;
            r_idx   <= '0;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 3'd1;
            end else begin
              r_idx <= '0;
              if (w_multi) begin
                r_frame <= w_next;
              end else if (w_push) begin
                r_frame <= w_in_frame;
              end
            end
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  // Stream outputs: everything is zero outside SEND so idle inputs never leak out.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_tag   = '0;
    bus.out_last  = 1'b0;
    if (r_state == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_data  = r_frame.bytes[r_idx];
      bus.out_tag   = r_frame.tag;
      bus.out_last  = (r_idx == LAST_IDX);
    end
  end

  // Saturating count of frames discarded because the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign bus.full     = w_full;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_sub1_out_packer.sv
// tb/tb_sub1_out_packer.sv - self-checking bench for sub1_out_packer
module tb_sub1_out_packer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  typedef struct {
    logic [1:0] tag;
    logic [7:0] b [6];
  } fr_t;

  typedef struct {
    bit         e;
    bit         rdy;
    bit         v;
    logic [7:0] d;
    bit         l;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] t;
    logic       l;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub1_out_packer_if #(.CNT_W(CNT_W)) bus ();

  sub1_out_packer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  rec_t rec_q [$];
  fr_t  eq [$];
  vec_t tbl [$];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    end
  endtask

  function automatic fr_t mk(input int s);
    fr_t f;
    f.tag = 2'(s);
    for (int i = 0; i < 6; i++) f.b[i] = 8'(s * 16 + i + 1);
    return f;
  endfunction

  function automatic fr_t rnd_frame();
    fr_t f;
    f.tag = 2'($urandom);
    for (int i = 0; i < 6; i++) f.b[i] = 8'($urandom);
    return f;
  endfunction

  task automatic set_frame(input fr_t f);
    bus.sig_f_0 = f.tag[0];
    bus.sig_f_1 = f.tag[1];
    bus.sig_g_0 = f.b[0];
    bus.sig_g_1 = f.b[1];
    bus.sig_g_2 = f.b[2];
    bus.sig_h_0 = f.b[3];
    bus.sig_h_1 = f.b[4];
    bus.sig_h_2 = f.b[5];
  endtask

  // Record a handshake seen before the edge, then step to just after the edge.
  task automatic tick();
    if (bus.out_valid && bus.out_ready)
      rec_q.push_back('{d: bus.out_data, t: bus.out_tag, l: bus.out_last});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.sig_e     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_q.delete();
    eq.delete();
  endtask

  task automatic push(input fr_t f);
    set_frame(f);
    bus.sig_e = 1'b1;
    tick();
    bus.sig_e = 1'b0;
  endtask

  task automatic drain(input int n);
    int cyc = 0;
    while (rec_q.size() < n && cyc < 200) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
  endtask

  task automatic check_stream(input string nm);
    int n;
    chk({nm, " byte count"}, rec_q.size(), eq.size() * 6);
    n = (rec_q.size() < eq.size() * 6) ? rec_q.size() : eq.size() * 6;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s byte %0d {tag,last,data}", nm, i),
          {rec_q[i].t, rec_q[i].l, rec_q[i].d},
          {eq[i/6].tag, (i % 6) == 5, eq[i/6].b[i%6]});
    end
  endtask

  function automatic void add(input bit e, input bit rdy, input bit v, input int d, input bit l);
    tbl.push_back('{e: e, rdy: rdy, v: v, d: 8'(d), l: l});
  endfunction

  // Stream/status snapshot; payload fields only meaningful while valid.
  function automatic int snap(input bit v, input int d, input int t, input bit l, input bit f, input int dc);
    if (!v) begin
      d = 0;
      t = 0;
      l = 1'b0;
    end
    return (int'(v) << 14) | ((d & 8'hff) << 6) | ((t & 3) << 4) | (int'(l) << 3) | (int'(f) << 2) | (dc & 3);
  endfunction

  initial begin
    fr_t  f;
    fr_t  mq [$];
    int   pos;
    int   mdrop;
    bit   mv;
    bit   e;
    bit   rdy;
    bit   hs;
    bit   acc;
    bit   was_empty;
    int   got_w;
    int   exp_w;
    int   cyc;
    int   nl;

    bus.sig_e = 1'b0;
    bus.out_ready = 1'b0;
    set_frame(mk(0));

    // Reset values while reset is held.
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset out_tag", bus.out_tag, 0);
    chk("reset out_last", bus.out_last, 0);
    chk("reset full", bus.full, 0);
    chk("reset drop_cnt", bus.drop_cnt, 0);
    do_reset();

    // Table: single frame at full rate, then the same frame under 1,0,0 backpressure.
    add(1, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) add(0, 1, 1, i, i == 6);
    add(0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0);
    for (int i = 2; i <= 6; i++) begin
      add(0, 1, 1, i, i == 6);
      add(0, 0, 1, i, i == 6);
      add(0, 0, 1, i, i == 6);
    end
    add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0);

    f.tag = 2'b10;
    for (int i = 0; i < 6; i++) f.b[i] = 8'(i + 1);
    set_frame(f);
    for (int r = 0; r < tbl.size(); r++) begin
      bus.sig_e     = tbl[r].e;
      bus.out_ready = tbl[r].rdy;
      tick();
      chk($sformatf("table row %0d {valid,data,tag,last}", r),
          snap(bus.out_valid, bus.out_data, bus.out_tag, bus.out_last, 1'b0, 0),
          snap(tbl[r].v, tbl[r].d, tbl[r].v ? 2 : 0, tbl[r].l, 1'b0, 0));
    end
    eq.push_back(f);
    eq.push_back(f);
    check_stream("table stream");

    // Overflow: five strobes into a two-deep FIFO with the sink stalled.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push(mk(k));
      if (k == 2) chk("overflow full after 2 pushes", bus.full, 1);
    end
    chk("overflow drop_cnt", bus.drop_cnt, 3);
    chk("overflow full", bus.full, 1);
    bus.out_ready = 1'b1;
    eq.push_back(mk(1));
    eq.push_back(mk(2));
    drain(12);
    check_stream("overflow stream");
    chk("overflow full after drain", bus.full, 0);

    // Push coinciding with the final-byte pop while full.
    do_reset();
    push(mk(7));
    push(mk(8));
    chk("samedge full before", bus.full, 1);
    bus.out_ready = 1'b1;
    cyc = 0;
    while (!(bus.out_valid && bus.out_last) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("samedge reached last byte", bus.out_last, 1);
    push(mk(9));
    chk("samedge drop_cnt", bus.drop_cnt, 0);
    chk("samedge full after", bus.full, 1);
    eq.push_back(mk(7));
    eq.push_back(mk(8));
    eq.push_back(mk(9));
    drain(18);
    check_stream("samedge stream");

    // Drop counter saturation.
    do_reset();
    push(mk(1));
    push(mk(2));
    for (int k = 1; k <= 6; k++) begin
      push(mk(3));
      if (k == 3) chk("saturate drop_cnt after 3", bus.drop_cnt, 3);
    end
    chk("saturate drop_cnt after 6", bus.drop_cnt, 3);

    // Reset in the middle of a frame with another frame queued.
    do_reset();
    push(mk(10));
    push(mk(11));
    push(mk(12));
    chk("midreset drop before", bus.drop_cnt, 1);
    bus.out_ready = 1'b1;
    cyc = 0;
    while (rec_q.size() < 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset full", bus.full, 0);
    chk("midreset drop_cnt", bus.drop_cnt, 0);
    rec_q.delete();
    repeat (10) tick();
    chk("midreset silent bytes", rec_q.size(), 0);
    push(mk(13));
    eq.push_back(mk(13));
    drain(6);
    check_stream("midreset new frame");
    nl = 0;
    foreach (rec_q[i]) nl += int'(rec_q[i].l);
    chk("midreset out_last count", nl, 1);

    // Randomized traffic against a queue-level reference model.
    do_reset();
    mq.delete();
    pos   = 0;
    mdrop = 0;
    mv    = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      e   = ($urandom_range(0, 99) < 35);
      rdy = ($urandom_range(0, 99) < 55);
      f   = rnd_frame();
      set_frame(f);
      bus.sig_e     = e;
      bus.out_ready = rdy;

      hs  = mv && rdy;
      acc = 1'b0;
      if (e) begin
        if (mq.size() < DEPTH || (hs && pos == 5)) acc = 1'b1;
        else if (mdrop < CMAX) mdrop++;
      end
      was_empty = (mq.size() == 0);
      if (hs) begin
        if (pos == 5) begin
          void'(mq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (acc) mq.push_back(f);
      mv = (mq.size() > 0) && !(acc && was_empty);

      tick();
      got_w = snap(bus.out_valid, bus.out_data, bus.out_tag, bus.out_last, bus.full, bus.drop_cnt);
      if (mv)
        exp_w = snap(1'b1, mq[0].b[pos], mq[0].tag, pos == 5, mq.size() == DEPTH, mdrop);
      else
        exp_w = snap(1'b0, 0, 0, 1'b0, mq.size() == DEPTH, mdrop);
      chk($sformatf("random cycle %0d {valid,data,tag,last,full,drop}", c), got_w, exp_w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
